// File: rtl/pc_pkg.sv
// Shared encodings for the program-counter unit: next-PC source selects and FSM states.
package pc_pkg;

    localparam logic [1:0] SEL_SEQ    = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_JUMP   = 2'b10;
    localparam logic [1:0] SEL_REG    = 2'b11;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } pc_state_t;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC generation: sequential, branch, jump and register targets plus select.
module pc_next_mux
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 4
) (
    input  logic [WIDTH-1:0] pc,
    input  logic [1:0]       sel,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] offset,
    input  logic [WIDTH-7:0] jump_index,
    input  logic [WIDTH-1:0] reg_target,
    output logic [WIDTH-1:0] pc_plus,
    output logic [WIDTH-1:0] target
);

    logic [WIDTH-1:0] branch_target;
    logic [WIDTH-1:0] jump_target;

    assign pc_plus       = pc + WIDTH'(STEP);
    // Offset counts words, so it is scaled to bytes before the add.
    assign branch_target = pc_plus + (offset << 2);
    assign jump_target   = {pc_plus[WIDTH-1:WIDTH-4], jump_index, 2'b00};

    always_comb begin
        target = pc_plus;
        case (sel)
            SEL_SEQ:    target = pc_plus;
            SEL_BRANCH: target = branch_taken ? branch_target : pc_plus;
            SEL_JUMP:   target = jump_target;
            SEL_REG:    target = reg_target;
            default:    target = pc_plus;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, update counter and optional misalignment trap FSM.
// Define PC_ALIGN_CHECK_EN to enable the misalignment check, TRAP state, epc and trap.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned     WIDTH        = 32,
    parameter int unsigned     STEP         = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_0000),
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0080)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic [1:0]       sel,
    input  logic             branchTaken,
    input  logic [WIDTH-1:0] offset,
    input  logic [WIDTH-7:0] jumpIndex,
    input  logic [WIDTH-1:0] regTarget,
    input  logic             trapAck,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] pcPlus,
    output logic [WIDTH-1:0] epc,
    output logic             trap,
    output logic [31:0]      count
);

    if (WIDTH < 16) begin : g_width_check
        $error("pc_unit: WIDTH must be at least 16");
    end

    logic [WIDTH-1:0] target;

    pc_next_mux #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_next_mux (
        .pc           (PC),
        .sel          (sel),
        .branch_taken (branchTaken),
        .offset       (offset),
        .jump_index   (jumpIndex),
        .reg_target   (regTarget),
        .pc_plus      (pcPlus),
        .target       (target)
    );

`ifdef PC_ALIGN_CHECK_EN
    pc_state_t state;
    logic      misaligned;

    assign misaligned = (target[1:0] != 2'b00);
    assign trap       = (state == ST_TRAP);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            PC    <= RESET_VECTOR;
            epc   <= '0;
            count <= '0;
            state <= ST_RUN;
        end else if (!stall) begin
            count <= count + 32'd1;
            if (misaligned) begin
                // Only the first fault is recorded; faults inside the handler keep it.
                PC    <= TRAP_VECTOR;
                state <= ST_TRAP;
                if (state == ST_RUN) begin
                    epc <= target;
                end
            end else begin
                PC <= target;
                if (state == ST_TRAP && trapAck) begin
                    state <= ST_RUN;
                end
            end
        end
    end
`else
    logic unused_trap_ack;

    assign unused_trap_ack = trapAck;
    assign trap            = 1'b0;
    assign epc             = '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            PC    <= RESET_VECTOR;
            count <= '0;
        end else if (!stall) begin
            PC    <= target;
            count <= count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit; expectations are hand-computed constants.
module tb_pc_unit;

    logic        clock;
    logic        reset;
    logic        stall;
    logic [1:0]  sel;
    logic        branchTaken;
    logic [31:0] offset;
    logic [25:0] jumpIndex;
    logic [31:0] regTarget;
    logic        trapAck;
    logic [31:0] PC;
    logic [31:0] pcPlus;
    logic [31:0] epc;
    logic        trap;
    logic [31:0] count;

    int n_cmp;
    int n_err;
    logic [31:0] exp_cnt;

    pc_unit #(
        .WIDTH        (32),
        .STEP         (4),
        .RESET_VECTOR (32'h0000_0000),
        .TRAP_VECTOR  (32'h0000_0080)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .sel         (sel),
        .branchTaken (branchTaken),
        .offset      (offset),
        .jumpIndex   (jumpIndex),
        .regTarget   (regTarget),
        .trapAck     (trapAck),
        .PC          (PC),
        .pcPlus      (pcPlus),
        .epc         (epc),
        .trap        (trap),
        .count       (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock edge; inputs stay as set, outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clock);
        #1;
        if (!stall) exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic load_reg(input logic [31:0] addr);
        stall     = 1'b0;
        sel       = 2'b11;
        regTarget = addr;
        step();
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        exp_cnt     = '0;
        reset       = 1'b1;
        stall       = 1'b0;
        sel         = 2'b00;
        branchTaken = 1'b0;
        offset      = '0;
        jumpIndex   = '0;
        regTarget   = '0;
        trapAck     = 1'b0;

        #12;
        check("reset_pc", PC, 32'h0);
        check("reset_pcplus", pcPlus, 32'h4);
        check("reset_count", count, 32'h0);
        check("reset_trap", {31'b0, trap}, 32'h0);
        check("reset_epc", epc, 32'h0);
        reset = 1'b0;

        // Sequential stepping
        step(); check("seq1_pc", PC, 32'h4);
        step(); check("seq2_pc", PC, 32'h8);
        step(); check("seq3_pc", PC, 32'hC);
        check("seq3_count", count, 32'd3);
        check("seq3_pcplus", pcPlus, 32'h10);

        // Branch taken with negative offset, then not taken
        load_reg(32'h100);
        check("load100_pc", PC, 32'h100);
        sel = 2'b01; branchTaken = 1'b1; offset = 32'hFFFF_FFFE;
        step(); check("branch_taken_pc", PC, 32'hFC);
        load_reg(32'h100);
        sel = 2'b01; branchTaken = 1'b0;
        step(); check("branch_not_taken_pc", PC, 32'h104);

        // Jump keeps upper nibble of PC+4
        load_reg(32'h1000_0010);
        sel = 2'b10; jumpIndex = 26'h40;
        step(); check("jump_pc", PC, 32'h1000_0100);
        check("jump_count", count, exp_cnt);

        // Stall holds PC and count
        load_reg(32'h20);
        stall = 1'b1; sel = 2'b00;
        step(); check("stall1_pc", PC, 32'h20);
        check("stall1_count", count, exp_cnt);
        step(); check("stall2_pc", PC, 32'h20);
        check("stall2_count", count, exp_cnt);
        stall = 1'b0;
        step(); check("stall_release_pc", PC, 32'h24);
        check("stall_release_count", count, exp_cnt);

        // Misaligned register target
        load_reg(32'h202);
`ifdef PC_ALIGN_CHECK_EN
        check("trap_entry_pc", PC, 32'h80);
        check("trap_entry_trap", {31'b0, trap}, 32'h1);
        check("trap_entry_epc", epc, 32'h202);
        load_reg(32'h306);
        check("trap_refault_pc", PC, 32'h80);
        check("trap_refault_epc", epc, 32'h202);
        check("trap_refault_trap", {31'b0, trap}, 32'h1);
        // Misalignment beats trapAck
        trapAck = 1'b1;
        load_reg(32'h301);
        check("trap_ack_misaligned_trap", {31'b0, trap}, 32'h1);
        check("trap_ack_misaligned_pc", PC, 32'h80);
        // Stall blocks trapAck
        stall = 1'b1; regTarget = 32'h300;
        step(); check("trap_ack_stalled_trap", {31'b0, trap}, 32'h1);
        check("trap_ack_stalled_pc", PC, 32'h80);
        load_reg(32'h300);
        check("trap_exit_pc", PC, 32'h300);
        check("trap_exit_trap", {31'b0, trap}, 32'h0);
        check("trap_exit_epc", epc, 32'h202);
        trapAck = 1'b0;
`else
        check("unchecked_pc", PC, 32'h202);
        check("unchecked_trap", {31'b0, trap}, 32'h0);
        check("unchecked_epc", epc, 32'h0);
        trapAck = 1'b1;
        load_reg(32'h301);
        check("unchecked_ack_pc", PC, 32'h301);
        check("unchecked_ack_trap", {31'b0, trap}, 32'h0);
        trapAck = 1'b0;
`endif
        check("pre_reset_count", count, exp_cnt);

        // Asynchronous reset mid-cycle after five updates
        reset = 1'b1; #2; reset = 1'b0;
        exp_cnt = '0;
        sel = 2'b00;
        for (int i = 0; i < 5; i++) step();
        check("five_count", count, 32'd5);
        check("five_pc", PC, 32'h14);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_pc", PC, 32'h0);
        check("async_reset_count", count, 32'h0);
        @(posedge clock);
        #1;
        check("held_reset_pc", PC, 32'h0);
        #2;
        reset = 1'b0;
        step(); check("post_reset_pc", PC, 32'h4);
        check("post_reset_count", count, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the processor datapath. It replaces the bare PC register and holds the fetch address. It computes the next address internally from the sequential, branch, jump and register-jump sources, and supports stalling. It also counts committed fetch updates and can trap on misaligned targets, redirecting fetch to a handler vector.

## Interface
Parameters:
- WIDTH, 32, address width; must be ≥ 16.
- STEP, 4, sequential increment in bytes.
- RESET_VECTOR, 0x0000_0000, PC value on reset.
- TRAP_VECTOR, 0x0000_0080, PC loaded on a misalignment trap.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- stall  in  1  hold PC, state and count this cycle.
- sel  in  2  next-PC source: 00 sequential, 01 branch, 10 jump, 11 register.
- branchTaken  in  1  qualifies sel=01; if low, the sequential address is used.
- offset  in  WIDTH  sign-extended word offset for branch.
- jumpIndex  in  WIDTH-6  word index for jump.
- regTarget  in  WIDTH  absolute byte target for register jump.
- trapAck  in  1  handler done; leave TRAP.
- PC  out  WIDTH  current fetch address (registered).
- pcPlus  out  WIDTH  PC+STEP (combinational).
- epc  out  WIDTH  faulting target captured on trap entry.
- trap  out  1  high while in TRAP.
- count  out  32  number of PC updates since reset.

## Operation
- Target computation, all arithmetic modulo 2^WIDTH with no overflow flag:
  - seq = PC+STEP.
  - branch = PC+STEP+(offset<<2).
  - jump = {pcPlus[WIDTH-1:WIDTH-4], jumpIndex, 2'b00}.
  - reg = regTarget.
- States: RUN, TRAP.
- RUN:
  - If stall, nothing changes.
  - Otherwise, if target[1:0]≠0 (check enabled): PC←TRAP_VECTOR, epc←target, go to TRAP.
  - Otherwise PC←target.
- TRAP:
  - The handler executes normally under the same target rules.
  - A misaligned target reloads PC←TRAP_VECTOR; epc is not overwritten, and the unit stays in TRAP.
  - trapAck (without stall) returns to RUN in the same edge, while PC loads its computed target or TRAP_VECTOR as above.
  - Misalignment together with trapAck means misalignment wins: the unit stays in TRAP.
- count increments on every non-stalled edge, including trap redirects, and wraps 0xFFFF_FFFF→0.
- stall also blocks trapAck.
- Reset values: PC=RESET_VECTOR, epc=0, trap=0, count=0, state RUN.

## Timing
- One-cycle latency: the target presented in cycle n appears on PC after the rising edge ending cycle n.
- trap rises together with PC=TRAP_VECTOR and falls on the edge that consumes trapAck.
- pcPlus follows PC combinationally within the same cycle.
- Reset asserted mid-operation forces reset values immediately, independent of clock. The first update occurs on the first rising edge after deassertion.
- stall is sampled only at the rising edge; there are no multi-cycle handshakes.

## Configuration
- PC_ALIGN_CHECK_EN defined: misalignment check, the TRAP state, epc and trap are active as described.
- Not defined:
  - All targets are loaded unchecked, including misaligned ones.
  - The state stays in RUN.
  - trap=0 and epc=0 constantly; trapAck is ignored.
  - Counting is unchanged.

## Structure
- Shared package pc_pkg holds:
  - sel encodings SEL_SEQ, SEL_BRANCH, SEL_JUMP, SEL_REG.
  - State encodings ST_RUN, ST_TRAP.
- Sub-module pc_next_mux is purely combinational and computes seq/branch/jump/reg and the selected target. pc_unit holds the registers, state machine and counter.

## Test plan
- Reset, then 3 edges with sel=00 → PC 0x0, 0x4, 0x8, 0xC; count=3.
- PC=0x100, sel=01, branchTaken=1, offset=−2 → PC=0xFC. With branchTaken=0 → PC=0x104.
- PC=0x1000_0010, sel=10, jumpIndex=0x40 → PC=0x1000_0100.
- Stall asserted 2 cycles at PC=0x20 → PC and count held; release → PC=0x24.
- With PC_ALIGN_CHECK_EN:
  - sel=11, regTarget=0x202 → PC=0x80, trap=1, epc=0x202.
  - A second misaligned target in TRAP → epc stays 0x202.
  - trapAck with sel=11, regTarget=0x300 → PC=0x300, trap=0.
- reset pulsed asynchronously mid-cycle with count=5 → PC=RESET_VECTOR and count=0 immediately, without waiting for a clock edge.
